// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Brief    : Shared definitions for the carry-chain TDC blocks: default chain
//            geometry, measurement FSM state set and fine-code width helper.
// Revision : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    // Default chain geometry, shared with the carry chain and readout blocks
    localparam int TDC_NUM_TAPS = 32;
    localparam int TDC_COARSE_W = 16;

    // Measurement controller state set
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ENCODE = 2'd2,
        HOLD   = 2'd3
    } tdc_state_e;

    // Minimum fine-code width able to represent 0..num_taps
    function automatic int tdc_fine_w(input int num_taps);
        return $clog2(num_taps + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_therm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tdc_therm_encoder
// Brief    : Combinational thermometer-to-count encoder. Returns the number of
//            consecutive ones starting at bit 0 of the tap snapshot.
//            Build option TDC_BUBBLE_FIX_EN: a 3-tap majority filter removes
//            single-tap bubbles before counting.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_therm_encoder #(
    parameter int NUM_TAPS = 32,
    parameter int FINE_W   = 6
) (
    input  logic [NUM_TAPS-1:0] snap_i,
    output logic [FINE_W-1:0]   fine_o
);

    logic [NUM_TAPS-1:0] corr;

`ifdef TDC_BUBBLE_FIX_EN
    // Padded view: below bit 0 the chain is treated as set, above the top as clear
    logic [NUM_TAPS+1:0] ext;
    assign ext = {1'b0, snap_i, 1'b1};

    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_majority
        assign corr[gi] = (ext[gi] & ext[gi+1]) | (ext[gi] & ext[gi+2]) | (ext[gi+1] & ext[gi+2]);
    end
`else
    assign corr = snap_i;
`endif

    // Leading-ones count from bit 0; everything above the first zero is ignored
    always_comb begin
        logic run;
        fine_o = '0;
        run    = 1'b1;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (run && corr[i]) begin
                fine_o = FINE_W'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdc_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tdc_meas_ctrl
// Brief    : TDC measurement controller. Arms a window, counts coarse cycles,
//            detects the rising hit edge on tap 0, encodes the snapshot into a
//            fine count and presents {coarse, fine, timeout} on valid/ready.
//            Build option TDC_BUBBLE_FIX_EN enables bubble correction in the
//            thermometer encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS = TDC_NUM_TAPS,
    parameter int COARSE_W = TDC_COARSE_W,
    parameter int FINE_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [NUM_TAPS-1:0] taps_q,
    output logic                busy,
    output logic                meas_valid,
    input  logic                meas_ready,
    output logic [COARSE_W-1:0] meas_coarse,
    output logic [FINE_W-1:0]   meas_fine,
    output logic                meas_timeout
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ARMED  = ARMED;
    localparam logic [1:0] S_ENCODE = ENCODE;
    localparam logic [1:0] S_HOLD   = HOLD;

    if (FINE_W < tdc_fine_w(NUM_TAPS)) begin : g_bad_fine_w
        $error("tdc_meas_ctrl: FINE_W too small for NUM_TAPS");
    end
    if ((NUM_TAPS % 4 != 0) || (NUM_TAPS < 8)) begin : g_bad_num_taps
        $error("tdc_meas_ctrl: NUM_TAPS must be a multiple of 4 and at least 8");
    end

    logic [1:0]          state_q, state_d;
    logic                bit0_q;
    logic [COARSE_W-1:0] cnt_q;
    logic [NUM_TAPS-1:0] snap_q;
    logic [COARSE_W-1:0] coarse_q;
    logic [FINE_W-1:0]   fine_q;
    logic                timeout_q;
    logic                hit_edge;
    logic                cnt_at_max;
    logic [FINE_W-1:0]   enc_fine;

    // Only a 0->1 transition on tap 0 counts; a chain already high stays ignored
    assign hit_edge   = taps_q[0] & ~bit0_q;
    assign cnt_at_max = (cnt_q == {COARSE_W{1'b1}});

    tdc_therm_encoder #(
        .NUM_TAPS (NUM_TAPS),
        .FINE_W   (FINE_W)
    ) u_enc (
        .snap_i (snap_q),
        .fine_o (enc_fine)
    );

    // Next-state decode; a hit on the terminal-count cycle takes priority
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (arm) state_d = S_ARMED;
            S_ARMED: begin
                if (hit_edge)        state_d = S_ENCODE;
                else if (cnt_at_max) state_d = S_HOLD;
            end
            S_ENCODE: state_d = S_HOLD;
            S_HOLD:   if (meas_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register and tap-0 history, the latter tracked in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit0_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bit0_q  <= taps_q[0];
        end
    end

    // Coarse counter and hit snapshot; the counter freezes at the hit value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (arm) cnt_q <= '0;
        end else if (state_q == S_ARMED) begin
            if (hit_edge)         snap_q <= taps_q;
            else if (!cnt_at_max) cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Result registers, written only on entry to HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse_q  <= '0;
            fine_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == S_ENCODE) begin
            coarse_q  <= cnt_q;
            fine_q    <= enc_fine;
            timeout_q <= 1'b0;
        end else if (state_q == S_ARMED && !hit_edge && cnt_at_max) begin
            coarse_q  <= {COARSE_W{1'b1}};
            fine_q    <= '0;
            timeout_q <= 1'b1;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign meas_valid   = (state_q == S_HOLD);
    assign meas_coarse  = coarse_q;
    assign meas_fine    = fine_q;
    assign meas_timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement controller for the carry-chain TDC. It arms a measurement window and counts coarse clock cycles. It detects the hit edge in the registered tap snapshot and encodes the thermometer code into a fine count. The result is a {coarse, fine, timeout} record delivered over a valid/ready handshake. It sits between the tap capture register and the timestamp readout/FIFO logic.

Parameters:
NUM_TAPS, 32, chain length in taps; multiple of 4, min 8
COARSE_W, 16, coarse counter width in bits
FINE_W, 6, fine code width; must be >= clog2(NUM_TAPS+1); elaboration error otherwise

Ports:
clk  in  1  system clock; also clocks the tap capture register
rst  in  1  reset, asynchronous, active-high
arm  in  1  single-cycle request to start a measurement window
taps_q  in  NUM_TAPS  registered chain snapshot; bit 0 nearest chain input
busy  out  1  high whenever state != IDLE
meas_valid  out  1  result available
meas_ready  in  1  consumer accepts result
meas_coarse  out  COARSE_W  cycles from window start to hit-detect cycle
meas_fine  out  FINE_W  corrected thermometer position, 0..NUM_TAPS
meas_timeout  out  1  window expired without a hit

Behaviour:
- Reset, asynchronous: state=IDLE; busy, meas_valid and meas_timeout = 0; meas_coarse, meas_fine and the coarse counter = 0; bit0_d = 1, which blocks a false edge on the first cycle.
- bit0_d is a register tracking taps_q[0] every cycle in every state.
- hit_edge = taps_q[0] & ~bit0_d. Only a rising edge qualifies, so a stale, still-high chain is never taken as a hit.
- IDLE: arm=1 -> ARMED; the coarse counter is cleared to 0.
- ARMED: the coarse counter increments by 1 per cycle.
  - hit_edge=1: latch taps_q and the current counter value (0 if the hit occurs in the first ARMED cycle), then go to ENCODE.
  - Otherwise, if the counter equals 2^COARSE_W-1: go to HOLD with meas_timeout=1, meas_coarse all-ones, meas_fine=0.
  - hit_edge and terminal count in the same cycle: the hit wins.
- ENCODE: one cycle; compute the fine code from the latched snapshot; -> HOLD.
- HOLD: meas_valid=1; all meas_* outputs stay stable until accepted.
  - meas_ready=1 -> IDLE; meas_valid deasserts the next cycle.
  - meas_ready may be high before valid rises; the transfer happens in the first cycle with both high.
- Latency: hit_edge in cycle N -> meas_valid high in cycle N+2. Timeout: valid in the cycle after terminal count.
- arm outside IDLE is ignored, including in the HOLD accept cycle; no queuing.
- Fine encoding: meas_fine = count of consecutive ones starting at bit 0 of the (optionally corrected) snapshot.
  - An all-ones snapshot gives NUM_TAPS.
  - Bits above the first zero are ignored.
- Output registers update only on ENCODE->HOLD or ARMED->HOLD transitions.
- rst asserted mid-measurement aborts immediately to reset values; no result is emitted.

Optional Feature:
TDC_BUBBLE_FIX_EN
- Defined: bubble correction is applied before the leading-ones count.
  - corrected[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[NUM_TAPS]=0.
  - Single-tap bubbles from metastability or routing skew are removed.
  - ENCODE latency is unchanged.
- Undefined: the raw snapshot is counted directly; no correction logic is present.

Decomposition:
- Shared package tdc_pkg holds:
  - state enum {IDLE, ARMED, ENCODE, HOLD};
  - clog2-based FINE_W helper function;
  - default NUM_TAPS and COARSE_W localparams, also used by the carry chain and readout blocks.
- One natural sub-module: tdc_therm_encoder. It is combinational: snapshot in, fine code out, and it contains the TDC_BUBBLE_FIX_EN logic. It is instanced once in ENCODE and unit-testable in isolation.

Test Plan:
- Basic hit (NUM_TAPS=32):
  - Stimulus: arm; taps_q=0 for 5 cycles, then 32'h0000_00FF; meas_ready=1.
  - Response: meas_coarse=5, meas_fine=8, meas_timeout=0; valid exactly 2 cycles after the hit cycle and high for 1 cycle.
- Bubble:
  - Stimulus: hit snapshot 32'h0000_01EF.
  - Response: meas_fine=9 with TDC_BUBBLE_FIX_EN, 4 without.
- Timeout (COARSE_W=4):
  - Stimulus: arm; taps_q held 0.
  - Response: meas_timeout=1, meas_coarse=4'hF, meas_fine=0, valid in the 17th cycle after arm.
- Stale chain and backpressure:
  - Stimulus: taps_q[0] held 1 before arm.
  - Response: no hit until taps_q[0] falls and rises again.
  - Stimulus: during HOLD, meas_ready=0 for 10 cycles.
  - Response: outputs stable; a second arm is ignored; busy=1 throughout.
- Edge cases:
  - Hit on the terminal-count cycle -> normal result with meas_timeout=0.
  - Full-chain snapshot 32'hFFFF_FFFF -> meas_fine=32.
  - rst pulsed during ARMED -> busy=0 and meas_valid=0 immediately; a subsequent arm measures correctly.
